// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants, flag bundle and configuration check for the pipelined
// carry-lookahead adder.
package cla_pipe_adder_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_STAGES = 2;
   localparam int DEF_BLOCK  = 4;

   typedef struct packed {
      logic cout;
      logic ovf;
      logic zero;
   } flags_t;

   // Every slice must be the same width and a whole number of lookahead groups.
   function automatic bit cfg_ok(input int width, input int stages, input int block);
      return (stages > 0) && (block > 0) && (width % stages == 0)
             && ((width / stages) % block == 0);
   endfunction

endpackage

// File: rtl/cla_pipe_adder_slice.sv
// One combinational adder slice: BLOCK-wide P/G lookahead groups with the
// group carries rippled from group to group.
module cla_slice
   import cla_pipe_adder_pkg::*;
#(
   parameter int SLICE_W = 8,
   parameter int BLOCK   = DEF_BLOCK
) (
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout,
   output logic               cmsb
);

   localparam int GROUPS = SLICE_W / BLOCK;

   logic [SLICE_W-1:0] p;
   logic [SLICE_W-1:0] g;
   logic [SLICE_W:0]   c;
   logic               grp_cin;
   logic               all_p;
   logic               term;
   logic               carry;

   assign p = a ^ b;
   assign g = a & b;

   // Carry into bit j of a group = G[j-1:0] | P[j-1:0] & group carry-in,
   // expanded as a flat sum of products rather than a bit-level ripple.
   always_comb begin
      c       = '0;
      all_p   = 1'b0;
      term    = 1'b0;
      carry   = 1'b0;
      grp_cin = cin;
      c[0]    = cin;
      for (int grp = 0; grp < GROUPS; grp++) begin
         for (int j = 1; j <= BLOCK; j++) begin
            all_p = 1'b1;
            for (int m = 0; m < j; m++) all_p = all_p & p[grp*BLOCK + m];
            carry = all_p & grp_cin;
            for (int m = 0; m < j; m++) begin
               term = g[grp*BLOCK + m];
               for (int n = m + 1; n < j; n++) term = term & p[grp*BLOCK + n];
               carry = carry | term;
            end
            c[grp*BLOCK + j] = carry;
         end
         grp_cin = carry;
      end
   end

   assign sum  = p ^ c[SLICE_W-1:0];
   assign cout = c[SLICE_W];
   assign cmsb = c[SLICE_W-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Skewed-pipeline adder/subtractor: one slice summed per stage, carry
// registered between stages, valid/ready handshake with no skid buffer.
module cla_pipe_adder
   import cla_pipe_adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES,
   parameter int BLOCK  = DEF_BLOCK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int SW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   if (!cfg_ok(WIDTH, STAGES, BLOCK)) begin : g_bad_cfg
      $error("cla_pipe_adder: WIDTH must split into STAGES slices of whole BLOCK groups");
   end

   logic [WIDTH-1:0]              b_eff;
   logic                          c0;
   logic [STAGES:0]               rdy;
   logic [STAGES-1:0]             v_q, v_d, pv;
   logic [STAGES-1:0]             c_q, c_d, pc;
   logic [STAGES-1:0][WIDTH-1:0]  a_q, a_d, pa;
   logic [STAGES-1:0][WIDTH-1:0]  b_q, b_d, pb;
   logic [STAGES-1:0][WIDTH-1:0]  s_q, s_d, ps;
   logic [STAGES-1:0][SW-1:0]     sl_s;
   logic [STAGES-1:0]             sl_co, sl_cm;
   flags_t                        flags_q, flags_d;
   logic                          unused_tail;

   assign b_eff = sub ? ~b : b;
   assign c0    = sub ? 1'b1 : cin;

   // Stage k sees either the transformed port operands or the previous stage's
   // registers; only slice k is summed, the other slices pass through untouched.
   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_entry
         assign pv[k] = in_valid;
         assign pa[k] = a;
         assign pb[k] = b_eff;
         assign ps[k] = '0;
         assign pc[k] = c0;
      end else begin : g_link
         assign pv[k] = v_q[k-1];
         assign pa[k] = a_q[k-1];
         assign pb[k] = b_q[k-1];
         assign ps[k] = s_q[k-1];
         assign pc[k] = c_q[k-1];
      end

      cla_slice #(
         .SLICE_W (SW),
         .BLOCK   (BLOCK)
      ) u_slice (
         .a    (pa[k][k*SW +: SW]),
         .b    (pb[k][k*SW +: SW]),
         .cin  (pc[k]),
         .sum  (sl_s[k]),
         .cout (sl_co[k]),
         .cmsb (sl_cm[k])
      );
   end

   always_comb begin
      rdy[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) rdy[i] = !v_q[i] || rdy[i+1];
   end

   always_comb begin
      v_d     = v_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      c_d     = c_q;
      flags_d = flags_q;
      for (int i = 0; i < STAGES; i++) begin
         if (rdy[i]) begin
            v_d[i]               = pv[i];
            a_d[i]               = pa[i];
            b_d[i]               = pb[i];
            s_d[i]               = ps[i];
            s_d[i][i*SW +: SW]   = sl_s[i];
            c_d[i]               = sl_co[i];
         end
      end
      if (rdy[LAST]) begin
         flags_d.cout = sl_co[LAST];
         flags_d.ovf  = sl_co[LAST] ^ sl_cm[LAST];
         flags_d.zero = (s_d[LAST] == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q     <= '0;
         s_q     <= '0;
         flags_q <= '0;
      end else begin
         v_q     <= v_d;
         s_q     <= s_d;
         flags_q <= flags_d;
      end
   end

   // Operand and carry registers only matter while their valid bit is set.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
   end

   // The last stage's operand copies and the intermediate MSB carries feed nothing.
   assign unused_tail = ^{a_q[LAST], b_q[LAST], c_q[LAST], sl_cm};

   assign in_ready  = rdy[0];
   assign out_valid = v_q[LAST];
   assign sum       = s_q[LAST];
   assign cout      = flags_q.cout;
   assign ovf       = flags_q.ovf;
   assign zero      = flags_q.zero;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder at default parameters (16 bits, 2 stages).
module tb_cla_pipe_adder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;
   logic        zero;

   int checks = 0;
   int errors = 0;

   cla_pipe_adder #(
      .WIDTH  (16),
      .STAGES (2),
      .BLOCK  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; a = 16'hDEAD; b = 16'hBEEF;
      cin = 1'b1; sub = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++;
      if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
      checks++;
      if ({cout, ovf, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {cout, ovf, zero}); end
   endtask

   task automatic test_arith();
      logic [15:0] va [8];
      logic [15:0] vb [8];
      logic        vs [8];
      logic        vc [8];
      logic [15:0] es [8];
      logic [2:0]  ef [8];
      va[0] = 16'h7FFF; vb[0] = 16'h0001; vs[0] = 0; vc[0] = 0; es[0] = 16'h8000; ef[0] = 3'b010;
      va[1] = 16'h0000; vb[1] = 16'h0001; vs[1] = 1; vc[1] = 0; es[1] = 16'hFFFF; ef[1] = 3'b000;
      va[2] = 16'h1234; vb[2] = 16'h1234; vs[2] = 1; vc[2] = 0; es[2] = 16'h0000; ef[2] = 3'b101;
      va[3] = 16'h00FF; vb[3] = 16'h0001; vs[3] = 0; vc[3] = 0; es[3] = 16'h0100; ef[3] = 3'b000;
      va[4] = 16'hFFFF; vb[4] = 16'h0000; vs[4] = 0; vc[4] = 1; es[4] = 16'h0000; ef[4] = 3'b101;
      va[5] = 16'h0005; vb[5] = 16'h0003; vs[5] = 1; vc[5] = 1; es[5] = 16'h0002; ef[5] = 3'b100;
      va[6] = 16'h8000; vb[6] = 16'h0001; vs[6] = 1; vc[6] = 0; es[6] = 16'h7FFF; ef[6] = 3'b110;
      va[7] = 16'h00FF; vb[7] = 16'h0000; vs[7] = 0; vc[7] = 1; es[7] = 16'h0100; ef[7] = 3'b000;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         in_valid = 1'b1; a = va[i]; b = vb[i]; sub = vs[i]; cin = vc[i];
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL arith%0d_in_ready: got %b expected 1", i, in_ready); end
         tick();
         in_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL arith%0d_early: out_valid %b expected 0 one cycle after accept", i, out_valid); end
         tick();
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL arith%0d_valid: got %b expected 1", i, out_valid); end
         checks++;
         if (sum !== es[i]) begin errors++; $display("FAIL arith%0d_sum: got %h expected %h", i, sum, es[i]); end
         checks++;
         if ({cout, ovf, zero} !== ef[i]) begin errors++; $display("FAIL arith%0d_flags: cout/ovf/zero got %b expected %b", i, {cout, ovf, zero}, ef[i]); end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_s [8];
      int got = 0;
      int first_cyc = -1;
      int last_cyc = -1;
      out_ready = 1'b1; sub = 1'b0; cin = 1'b0;
      for (int i = 0; i < 8; i++) exp_s[i] = (16'h1F00 + 16'(i) * 16'h0111) + (16'h00F0 + 16'(i));
      for (int cyc = 0; cyc < 20; cyc++) begin
         tick();
         if (cyc < 8) begin
            in_valid = 1'b1;
            a = 16'h1F00 + 16'(cyc) * 16'h0111;
            b = 16'h00F0 + 16'(cyc);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (cyc < 8) begin
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready%0d: got %b expected 1", cyc, in_ready); end
         end
         if (out_valid === 1'b1 && got < 8) begin
            checks++;
            if (sum !== exp_s[got]) begin errors++; $display("FAIL b2b_sum%0d: got %h expected %h", got, sum, exp_s[got]); end
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            got++;
         end
      end
      checks++;
      if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d results expected 8", got); end
      checks++;
      if (last_cyc - first_cyc != 7) begin errors++; $display("FAIL b2b_spacing: results spanned %0d cycles expected 7", last_cyc - first_cyc); end
   endtask

   task automatic test_backpressure();
      localparam int N = 6;
      logic [15:0] exp_s [N];
      logic [15:0] held;
      logic        stalled = 1'b0;
      logic        saw_low = 1'b0;
      int pidx = 0;
      int cidx = 0;
      sub = 1'b0; cin = 1'b0;
      for (int i = 0; i < N; i++) exp_s[i] = (16'h0100 * 16'(i + 1) + 16'h00C0) + 16'h0050;
      held = 16'h0000;
      for (int cyc = 0; cyc < 40 && cidx < N; cyc++) begin
         tick();
         out_ready = !(cyc >= 4 && cyc <= 6);
         in_valid  = (pidx < N);
         a = 16'h0100 * 16'(pidx + 1) + 16'h00C0;
         b = 16'h0050;
         @(negedge clk);
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || sum !== held) begin
               errors++; $display("FAIL bp_hold: valid %b sum %h expected valid 1 sum %h", out_valid, sum, held);
            end
         end
         stalled = out_valid && !out_ready;
         held = sum;
         if (!in_ready) saw_low = 1'b1;
         if (in_valid && in_ready) pidx++;
         if (out_valid && out_ready && cidx < N) begin
            checks++;
            if (sum !== exp_s[cidx]) begin errors++; $display("FAIL bp_sum%0d: got %h expected %h", cidx, sum, exp_s[cidx]); end
            cidx++;
         end
      end
      checks++;
      if (cidx != N) begin errors++; $display("FAIL bp_count: got %0d results expected %0d", cidx, N); end
      checks++;
      if (saw_low !== 1'b1) begin errors++; $display("FAIL bp_in_ready_low: in_ready never dropped under stall"); end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: out_valid %b expected 0 after drain", out_valid); end
   endtask

   task automatic test_reset_midflight();
      tick();
      out_ready = 1'b0; in_valid = 1'b1; sub = 1'b0; cin = 1'b0;
      a = 16'h1111; b = 16'h2222;
      tick();
      a = 16'h3333; b = 16'h4444;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_full_valid: got %b expected 1", out_valid); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_full_in_ready: got %b expected 0", in_ready); end
      tick();
      rst = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; out_ready = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
      checks++;
      if (sum !== 16'h0000) begin errors++; $display("FAIL mid_rst_sum: got %h expected 0000", sum); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_in_ready: got %b expected 1", in_ready); end
      checks++;
      if ({cout, ovf, zero} !== 3'b000) begin errors++; $display("FAIL mid_rst_flags: got %b expected 000", {cout, ovf, zero}); end
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale%0d: out_valid %b expected 0", i, out_valid); end
      end
      tick();
      in_valid = 1'b1; a = 16'h0003; b = 16'h0004;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_fresh_early: out_valid %b expected 0", out_valid); end
      tick();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || sum !== 16'h0007) begin
         errors++; $display("FAIL mid_fresh_result: valid %b sum %h expected valid 1 sum 0007", out_valid, sum);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      test_reset();
      test_arith();
      test_back_to_back();
      test_backpressure();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
